// File: rtl/pe_accum_ctrl.sv
// Accumulation controller: streams signed elements into an external PE adder
// and returns the registered sum with a sticky signed-overflow flag.
module pe_accum_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [CNT_WIDTH-1:0]         len,
    output logic                         busy,
    input  logic                         in_valid,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    output logic                         in_ready,
    output logic signed [DATA_WIDTH-1:0] pe_in1,
    output logic signed [DATA_WIDTH-1:0] pe_in2,
    output logic                         pe_set_reg,
    input  logic signed [DATA_WIDTH-1:0] pe_psum,
    output logic                         out_valid,
    output logic signed [DATA_WIDTH-1:0] out_data,
    input  logic                         out_ready,
    output logic                         ovf
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_WAIT,
        S_DONE
    } state_t;

    localparam int MSB = DATA_WIDTH - 1;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0]         cnt, cnt_nxt;
    logic [CNT_WIDTH-1:0]         len_q, len_nxt;
    logic                         ovf_nxt;
    logic signed [DATA_WIDTH-1:0] out_nxt;
    logic signed [DATA_WIDTH-1:0] sum;
    logic                         xfer;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            len_q    <= '0;
            out_data <= '0;
            ovf      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            len_q    <= len_nxt;
            out_data <= out_nxt;
            ovf      <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        len_nxt    = len_q;
        ovf_nxt    = ovf;
        out_nxt    = out_data;
        busy       = 1'b0;
        in_ready   = 1'b0;
        pe_in1     = '0;
        pe_in2     = '0;
        pe_set_reg = 1'b0;
        out_valid  = 1'b0;
        xfer       = 1'b0;
        sum        = in_data + pe_psum;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    len_nxt   = len;
                    cnt_nxt   = '0;
                    ovf_nxt   = 1'b0;
                    state_nxt = S_CLEAR;
                end
            end
            S_CLEAR: begin
                busy       = 1'b1;
                pe_set_reg = 1'b1;
                state_nxt  = (len_q != '0) ? S_ACCUM : S_WAIT;
            end
            S_ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                xfer     = in_valid;
                if (xfer) begin
                    pe_in1     = in_data;
                    pe_in2     = pe_psum;
                    pe_set_reg = 1'b1;
                    cnt_nxt    = cnt + 1'b1;
                    // Like-signed operands producing an opposite-signed sum
                    if (in_data[MSB] == pe_psum[MSB] &&
                        sum[MSB] != in_data[MSB])
                        ovf_nxt = 1'b1;
                    if (cnt_nxt == len_q)
                        state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                busy      = 1'b1;
                out_nxt   = pe_psum;
                state_nxt = S_DONE;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase

        // Hold the PE and stream ports quiet while reset is asserted
        if (rst_n) begin
            busy       = 1'b0;
            in_ready   = 1'b0;
            pe_in1     = '0;
            pe_in2     = '0;
            pe_set_reg = 1'b0;
            out_valid  = 1'b0;
        end
    end

endmodule

// File: doc/pe_accum_ctrl.md
PE_ACCUM_CTRL -- requirements
Module: pe_accum_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, width of data, PE operands and sum.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, width of vector length and element counter.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n  input  1  synchronous, active-high reset (1 = reset), sampled on the clk rising edge.
REQ-005 SHALL have port start  input  1  begin one accumulation job; sampled only in IDLE.
REQ-006 SHALL have port len  input  CNT_WIDTH  number of elements in the job; latched when start is accepted.
REQ-007 SHALL have port busy  output  1  high in every state except IDLE.
REQ-008 SHALL have ports in_valid (input, 1), in_data (input, DATA_WIDTH, signed) and in_ready (output, 1): element stream; transfer occurs when in_valid & in_ready.
REQ-009 SHALL have ports pe_in1 and pe_in2 (output, DATA_WIDTH, signed) driving the PE adder operands, and pe_set_reg (output, 1) driving the PE psum register load.
REQ-010 SHALL have port pe_psum  input  DATA_WIDTH  registered PE sum; it equals the registered pe_in1 + pe_in2 one cycle after pe_set_reg = 1.
REQ-011 SHALL have ports out_valid (output, 1), out_data (output, DATA_WIDTH, signed), out_ready (input, 1) and ovf (output, 1, sticky signed-overflow flag for the current job).

Function
REQ-012 SHALL implement the states IDLE, CLEAR, ACCUM, WAIT and DONE.
REQ-013 IDLE: on start = 1 SHALL latch len, clear the counter and ovf, and go to CLEAR.
REQ-014 CLEAR: SHALL drive pe_in1 = 0, pe_in2 = 0 and pe_set_reg = 1 for exactly one cycle, then go to ACCUM if len != 0, else to WAIT.
REQ-015 ACCUM: in_ready SHALL be 1.
REQ-016 ACCUM: on each transfer, SHALL combinationally drive pe_in1 = in_data, pe_in2 = pe_psum and pe_set_reg = 1 in the same cycle, and increment the counter.
REQ-017 ACCUM: with no transfer, pe_set_reg SHALL be 0 and the PE sum SHALL be held.
REQ-018 ACCUM: the transfer that makes the count equal to the latched len SHALL move the FSM to WAIT; no further elements are accepted.
REQ-019 WAIT: SHALL last exactly one cycle, register out_data <= pe_psum, then go to DONE.
REQ-020 DONE: out_valid SHALL be 1 and out_data stable; on out_ready = 1 SHALL go to IDLE. out_valid SHALL NOT drop without out_ready.
REQ-021 Latency: out_valid SHALL rise 2 cycles after the clock edge that accepts the last element; for len = 0, 3 cycles after the edge that accepts start.
REQ-022 Arithmetic SHALL wrap modulo 2^DATA_WIDTH, two's complement, with no saturation.
REQ-023 ovf SHALL set when a transfer has sign(in_data) == sign(pe_psum) != sign(in_data + pe_psum), and SHALL stay set until the next start acceptance or reset.
REQ-024 Outside CLEAR and ACCUM transfers, pe_in1, pe_in2 and pe_set_reg SHALL be 0.
REQ-025 in_ready SHALL be 0 outside ACCUM; in_valid outside ACCUM SHALL be ignored.
REQ-026 start SHALL be ignored outside IDLE, including in DONE; len changes after acceptance SHALL have no effect.
REQ-027 start and out_ready asserted together in DONE SHALL return the FSM to IDLE only; the new start SHALL be taken no earlier than the next cycle in IDLE.
REQ-028 len = 2^CNT_WIDTH - 1 SHALL be supported without counter wrap.

Reset
REQ-029 rst_n = 1 SHALL force IDLE, counter = 0, latched len = 0, out_data = 0, out_valid = 0, ovf = 0, in_ready = 0, busy = 0, pe_set_reg = 0, pe_in1 = 0 and pe_in2 = 0, from any state.
REQ-030 Reset mid-job SHALL abandon the job; the next job SHALL start cleanly via CLEAR, independent of stale pe_psum.

Verification
REQ-031 Inputs len = 4, data 1, 2, 3, 4, in_valid continuous -> out_data = 10, ovf = 0, out_valid 2 cycles after the 4th transfer edge.
REQ-032 Inputs len = 3, data -5, 7, -1, in_valid toggling 1-0-1-0-1 -> exactly 3 transfers, out_data = 1, pe_set_reg pulses only on transfers.
REQ-033 Inputs len = 2, data 0x7FFF, 0x0001 -> out_data = 0x8000 and ovf = 1; the next job with data 1, 1 -> ovf = 0, out_data = 2.
REQ-034 Inputs len = 0 -> no in_ready, out_data = 0, out_valid 3 cycles after start.
REQ-035 Hold out_ready = 0 for 5 cycles in DONE while pulsing start -> out_valid and out_data held, start ignored; a start in IDLE afterwards is accepted.
REQ-036 Assert rst_n after the 2nd of 4 elements -> all outputs take their reset values next cycle; a new job with len = 2, data 3, 4 -> out_data = 7.
